tft_line_fetch: RTL and testbench

- Upstream image source for the TFT timing controller; drives its pixel data input.
- Fetches each display line from an external read-only image memory into a ping-pong line buffer one line ahead of display.
- Presents the pixel for the controller's current image-area coordinates (hcnt, vcnt) with zero apparent latency.
- Sits between the frame memory read port and the TFT controller, on the 9 MHz pixel clock.

---
 rtl/tft_line_fetch.sv | 186 ++++++++++++++++++
 tb/tb_tft_line_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tft_line_fetch
// Brief    : Ping-pong line prefetcher feeding the TFT controller pixel input.
//            Optional colour-bar generator enabled by TFT_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tft_line_fetch #(
    parameter int H_ACT   = 480,
    parameter int V_ACT   = 272,
    parameter int ADDR_W  = 17,
    parameter int MAX_OUT = 4
) (
    input  logic              clk9M,
    input  logic              rst_n,
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
`ifdef TFT_TEST_PATTERN_EN
    input  logic              pat_sel,
`endif
    output logic [15:0]       data_out,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic              mem_rd_valid,
    input  logic [15:0]       mem_rd_data,
    output logic              line_busy,
    output logic              underrun
);

    localparam int c_COL_W = $clog2(H_ACT + 1);
    localparam int c_IDX_W = $clog2(H_ACT);
    localparam int c_OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE = c_COL_W'(1);
    localparam logic [c_COL_W-1:0] c_COL_END = c_COL_W'(H_ACT);
    localparam logic [c_COL_W-1:0] c_COL_LST = c_COL_W'(H_ACT - 1);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);
    localparam logic [c_OUT_W-1:0] c_OUT_MAX = c_OUT_W'(MAX_OUT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_bank;
    logic [ADDR_W-1:0]   r_acc_base;
    logic [ADDR_W-1:0]   r_base;
    logic [c_COL_W-1:0]  r_req_col;
    logic [c_COL_W-1:0]  r_wr_col;
    logic [c_OUT_W-1:0]  r_out;
    logic [15:0]         r_data;
    logic [15:0]         r_buf [0:1][0:H_ACT-1];

    logic [9:0]          w_tgt;
    logic [9:0]          w_la;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_trig;
    logic [ADDR_W-1:0]   w_new_base;
    logic                w_req;
    logic                w_acc;
    logic                w_ret;
    logic                w_rd_ok;
    logic [15:0]         w_pix;

    assign w_trig = (hcnt == 10'd0) &&
                    ((vcnt == 10'h3FF) || (vcnt < 10'(V_ACT - 1)));
    assign w_tgt  = vcnt + 10'd1;

    // Triggers arrive in line order each frame, starting with the line-0
    // prefetch, so the next base is the previous one plus a line.
    assign w_new_base = (w_tgt == 10'd0) ? '0 : (r_acc_base + ADDR_W'(H_ACT));

    assign w_req = (r_state == S_FETCH) && (r_req_col < c_COL_END) &&
                   (r_out < c_OUT_MAX);
    assign w_acc = w_req && mem_rd_ack;
    assign w_ret = (r_state == S_FETCH) && mem_rd_valid && (r_out != '0);

    assign mem_rd_req  = w_req;
    assign mem_rd_addr = r_base + ADDR_W'(r_req_col);
    assign line_busy   = r_busy;
    assign underrun    = w_trig && r_busy;
    assign data_out    = r_data;

    always_ff @(posedge clk9M or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_bank     <= 1'b0;
            r_acc_base <= '0;
            r_base     <= '0;
            r_req_col  <= '0;
            r_wr_col   <= '0;
            r_out      <= '0;
        end else begin
            if (w_trig) begin
                r_acc_base <= w_new_base;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_state   <= S_FETCH;
                        r_busy    <= 1'b1;
                        r_bank    <= w_tgt[0];
                        r_base    <= w_new_base;
                        r_req_col <= '0;
                        r_wr_col  <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_acc) begin
                        r_req_col <= r_req_col + c_COL_ONE;
                    end
                    case ({w_acc, w_ret})
                        2'b10:   r_out <= r_out + c_OUT_ONE;
                        2'b01:   r_out <= r_out - c_OUT_ONE;
                        default: r_out <= r_out;
                    endcase
                    if (w_ret) begin
                        r_wr_col <= r_wr_col + c_COL_ONE;
                        if (r_wr_col == c_COL_LST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk9M) begin
        if (w_ret) begin
            r_buf[r_bank][r_wr_col[c_IDX_W-1:0]] <= mem_rd_data;
        end
    end

    // One column of lookahead hides the buffer read register.
    assign w_la    = hcnt + 10'd1;
    assign w_idx   = w_la[c_IDX_W-1:0];
    assign w_rd_ok = (w_la < 10'(H_ACT)) && (vcnt < 10'(V_ACT));

`ifdef TFT_TEST_PATTERN_EN
    logic [2:0]  w_bar;
    logic [15:0] w_pat;

    always_comb begin
        w_bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (w_la >= 10'(i * (H_ACT / 8))) begin
                w_bar = 3'(i);
            end
        end
        case (w_bar)
            3'd0:    w_pat = 16'hFFFF;
            3'd1:    w_pat = 16'hFFE0;
            3'd2:    w_pat = 16'h07FF;
            3'd3:    w_pat = 16'h07E0;
            3'd4:    w_pat = 16'hF81F;
            3'd5:    w_pat = 16'hF800;
            3'd6:    w_pat = 16'h001F;
            default: w_pat = 16'h0000;
        endcase
    end
`endif

    always_comb begin
        w_pix = r_buf[vcnt[0]][w_idx];
`ifdef TFT_TEST_PATTERN_EN
        if (pat_sel) begin
            w_pix = w_pat;
        end
`endif
    end

    always_ff @(posedge clk9M or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_rd_ok ? w_pix : 16'h0000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tft_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_tft_line_fetch
// Brief    : Self-checking bench for tft_line_fetch with a queued memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tft_line_fetch;

    localparam int H_ACT   = 480;
    localparam int V_ACT   = 272;
    localparam int ADDR_W  = 17;
    localparam int MAX_OUT = 4;
    localparam int H_LAST  = 599;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [9:0]        hcnt;
    logic [9:0]        vcnt;
    logic [15:0]       data_out;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic              mem_rd_valid;
    logic [15:0]       mem_rd_data;
    logic              line_busy;
    logic              underrun;
`ifdef TFT_TEST_PATTERN_EN
    logic              pat_sel;
`endif

    always #55 clk = ~clk;

    tft_line_fetch #(
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .ADDR_W (ADDR_W),
        .MAX_OUT(MAX_OUT)
    ) dut (
        .clk9M       (clk),
        .rst_n       (rst_n),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
`ifdef TFT_TEST_PATTERN_EN
        .pat_sel     (pat_sel),
`endif
        .data_out    (data_out),
        .mem_rd_req  (mem_rd_req),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_ack  (mem_rd_ack),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data (mem_rd_data),
        .line_busy   (line_busy),
        .underrun    (underrun)
    );

    typedef struct {
        logic [15:0] d;
        int          due;
        int          ep;
    } rd_t;

    rd_t               q[$];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    int                lat      = 2;
    bit                lat_rand = 1'b0;
    int                ack_mode = 0;
    int                epoch    = 0;
    int                m_out    = 0;
    int                exp_idx  = H_ACT;
    int                exp_base = 0;
    logic [15:0]       seed     = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_f(input int a);
        logic [31:0] av;
        av = a;
        return av[15:0] ^ seed;
    endfunction

    function automatic logic [15:0] model_pix(input int h, input int v);
        logic [15:0] bars [8];
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (v >= V_ACT || h >= H_ACT) return 16'h0000;
`ifdef TFT_TEST_PATTERN_EN
        if (pat_sel) return bars[h / 60];
`endif
        return mem_f(v * H_ACT + h);
    endfunction

    // Memory: ack policy, in-order returns, request address scoreboard.
    initial begin
        rd_t e;
        int  due;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = 16'h0000;
        forever begin
            @(negedge clk);
            cyc++;
            case (ack_mode)
                0:       mem_rd_ack = 1'b1;
                1:       mem_rd_ack = ($urandom_range(15, 0) != 0);
                default: mem_rd_ack = ((cyc % 4) == 0);
            endcase
            if (rst_n && mem_rd_req) begin
                check("out_cap", 32'(m_out < MAX_OUT), 32'd1);
                if (mem_rd_ack) begin
                    check("req_in_range", 32'(exp_idx < H_ACT), 32'd1);
                    check("req_addr", 32'(mem_rd_addr), 32'(exp_base + exp_idx));
                    exp_idx++;
                    due = cyc + (lat_rand ? int'($urandom_range(3, 1)) : lat);
                    if (q.size() > 0 && due < q[$].due) due = q[$].due;
                    e.d   = mem_f(int'(mem_rd_addr));
                    e.due = due;
                    e.ep  = epoch;
                    q.push_back(e);
                    m_out++;
                end
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                mem_rd_valid = 1'b1;
                mem_rd_data  = e.d;
                if (e.ep == epoch) m_out--;
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = 16'h0000;
            end
        end
    end

    // chkm: 0 = no pixel check, 1 = every column, 2 = only columns >= H_ACT
    task automatic step(input int h, input int v, input int chkm, input bit ur_exp);
        hcnt = 10'(h);
        vcnt = 10'(v);
        @(negedge clk);
        if (chkm == 1 || (chkm == 2 && h >= H_ACT))
            check($sformatf("pix_v%0d_h%0d", v, h), 32'(data_out), 32'(model_pix(h, v)));
        check("underrun", 32'(underrun), 32'(ur_exp));
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input int v, input int chkm, input bit acc, input bit ur0);
        step(1023, v, chkm, 1'b0);
        if (acc) begin
            exp_base = ((v + 1) % 1024) * H_ACT;
            exp_idx  = 0;
        end
        for (int h = 0; h <= H_LAST; h++) step(h, v, chkm, (h == 0) ? ur0 : 1'b0);
    endtask

    initial begin
        int n;
        int h;
        rst_n = 1'b0;
        hcnt  = 10'd300;
        vcnt  = 10'd300;
`ifdef TFT_TEST_PATTERN_EN
        pat_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_req", 32'(mem_rd_req), 32'd0);
        check("rst_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_busy", 32'(line_busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;

        // Line-0 prefetch with a fixed-latency, always-accepting memory
        run_line(1023, 1, 1'b1, 1'b0);
        check("busy_done_l0", 32'(line_busy), 32'd0);
        check("req_total_l0", 32'(exp_idx), 32'(H_ACT));
        run_line(0, 1, 1'b1, 1'b0);

        // Randomised ack and latency, continuous lines
        ack_mode = 1;
        lat_rand = 1'b1;
        for (int v = 1; v <= 5; v++) run_line(v, 1, 1'b1, 1'b0);

        // Starved memory: the next trigger lands while still busy
        ack_mode = 2;
        lat_rand = 1'b0;
        lat      = 2;
        run_line(6, 1, 1'b1, 1'b0);
        run_line(7, 0, 1'b0, 1'b1);
        check("busy_starved", 32'(line_busy), 32'd1);
        ack_mode = 0;
        n = 0;
        while (line_busy && n < 3000) begin
            step(600 + (n % 400), 272, 1, 1'b0);
            n++;
        end
        check("busy_drop", 32'(line_busy), 32'd0);
        check("req_total_l7", 32'(exp_idx), 32'(H_ACT));

        // Last active line and blanking: no triggers
        run_line(V_ACT - 1, 2, 1'b0, 1'b0);
        run_line(V_ACT, 1, 1'b0, 1'b0);
        run_line(285, 1, 1'b0, 1'b0);
        check("req_total_blank", 32'(exp_idx), 32'(H_ACT));

        // Reset in the middle of a fetch with reads in flight
        lat = 3;
        step(1023, 1023, 0, 1'b0);
        exp_base = 0;
        exp_idx  = 0;
        h = 0;
        while (exp_idx < 200 && h < 600) begin
            step(h, 1023, 0, 1'b0);
            h++;
        end
        check("req_col_200", 32'(exp_idx), 32'd200);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_rd_req), 32'd0);
        check("mid_rst_addr", 32'(mem_rd_addr), 32'd0);
        check("mid_rst_busy", 32'(line_busy), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        epoch++;
        m_out   = 0;
        exp_idx = H_ACT;
        step(300, 1023, 0, 1'b0);
        step(301, 1023, 0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(302 + i, 1023, 1, 1'b0);
        check("post_rst_busy", 32'(line_busy), 32'd0);
        seed = 16'($urandom);
        run_line(1023, 1, 1'b1, 1'b0);
        run_line(0, 1, 1'b1, 1'b0);
        run_line(1, 1, 1'b1, 1'b0);

`ifdef TFT_TEST_PATTERN_EN
        pat_sel = 1'b1;
        run_line(2, 1, 1'b1, 1'b0);
        pat_sel = 1'b0;
        run_line(3, 1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
